// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-port signals of the arbiter, bundled as one bus.
// Handshake: a requester holds x_req and its fields until x_gnt is seen high in
// the same cycle; m_req holds with stable fields until the cycle m_ack is high;
// x_rvalid is a single-cycle pulse with no backpressure.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_wmask;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_wmask;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    // master: the arbiter, which owns the memory port and answers both requesters
    modport master (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_wmask, m_ack, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_wen, m_addr, m_wdata, m_wmask
    );

    modport slave (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_wmask, m_ack, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_wen, m_addr, m_wdata, m_wmask
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data first, fetch when alone or when starved.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  logic   starved,
    output logic   valid,
    output owner_t winner
);

    always_comb begin
        valid  = i_req | d_req;
        winner = OWN_D;
        if (i_req && (!d_req || starved)) begin
            winner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction in flight, with a starvation bound on consecutive data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.master    bus,
    output state_t           dbg_state,
    output logic [CNT_W-1:0] dbg_starve_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             pick_valid;
    owner_t           pick_owner;
    logic             arb_en;

    mem_arb_pick u_pick (
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
        .starved (starve_cnt == CNT_MAX),
        .valid   (pick_valid),
        .winner  (pick_owner)
    );

    // Grants are only offered in IDLE and never while reset is held.
    assign arb_en    = (state == IDLE) && !rst && pick_valid;
    assign bus.i_gnt = arb_en && (pick_owner == OWN_I);
    assign bus.d_gnt = arb_en && (pick_owner == OWN_D);

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            bus.m_req    <= 1'b0;
            bus.m_wen    <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.m_wmask  <= '0;
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.d_rdata  <= '0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        bus.m_req <= 1'b1;
                        if (pick_owner == OWN_I) begin
                            state       <= BUSY_I;
                            bus.m_wen   <= 1'b0;
                            bus.m_addr  <= bus.i_addr;
                            bus.m_wdata <= '0;
                            bus.m_wmask <= '0;
                            starve_cnt  <= '0;
                        end else begin
                            state       <= BUSY_D;
                            bus.m_wen   <= bus.d_wen;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                            bus.m_wmask <= bus.d_wmask;
                            // Only count data grants that actually made fetch wait.
                            if (!bus.i_req) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != CNT_MAX) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.m_ack) begin
                        bus.m_req <= 1'b0;
                        state     <= IDLE;
                        if (state == BUSY_I) begin
                            bus.i_rdata  <= bus.m_rdata;
                            bus.i_rvalid <= 1'b1;
                        end else begin
                            bus.d_rdata  <= bus.m_rdata;
                            bus.d_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic
// against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SMAX  = 4;
    localparam int CNT_W = $clog2(SMAX + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    state_t           dbg_state;
    logic [CNT_W-1:0] dbg_starve_cnt;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (mif),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            m_busy;
    logic          m_own;
    logic [AW-1:0] e_addr;
    logic          e_wen;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_wmask;
    int            starve;
    logic [DW-1:0] last_i;
    logic [DW-1:0] last_d;
    logic [DW:0]   exp_q[$];
    logic          grant_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_own  = OWN_I;
        starve = 0;
        last_i = '0;
        last_d = '0;
        exp_q.delete();
    endtask

    // Registered outputs, sampled at the falling edge.
    task automatic check_outputs();
        logic [DW:0] e;
        state_t      exp_st;
        exp_st = !m_busy ? IDLE : ((m_own == OWN_I) ? BUSY_I : BUSY_D);
        check("m_req", mif.m_req, m_busy);
        check("state", dbg_state, exp_st);
        check("starve_cnt", dbg_starve_cnt, starve);
        if (m_busy) begin
            check("m_addr", mif.m_addr, e_addr);
            check("m_wen", mif.m_wen, e_wen);
            if (m_own == OWN_D) begin
                check("m_wdata", mif.m_wdata, e_wdata);
                check("m_wmask", mif.m_wmask, e_wmask);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[DW] == OWN_I) last_i = e[DW-1:0];
            else                last_d = e[DW-1:0];
            check("i_rvalid", mif.i_rvalid, e[DW] == OWN_I);
            check("d_rvalid", mif.d_rvalid, e[DW] == OWN_D);
        end else begin
            check("i_rvalid", mif.i_rvalid, 1'b0);
            check("d_rvalid", mif.d_rvalid, 1'b0);
        end
        check("i_rdata", mif.i_rdata, last_i);
        check("d_rdata", mif.d_rdata, last_d);
    endtask

    // One clock: requests already driven; memory drives ack/rdata here.
    task automatic tick(input logic ack, input logic [DW-1:0] rdata);
        logic want_i, want_d, gi, gd;
        mif.m_ack   = ack;
        mif.m_rdata = rdata;
        #1;
        want_i = mif.i_req;
        want_d = mif.d_req;
        gi = 1'b0;
        gd = 1'b0;
        if (!m_busy) begin
            if (want_i && want_d) begin
                if (starve == SMAX) gi = 1'b1;
                else                gd = 1'b1;
            end else begin
                gi = want_i;
                gd = want_d;
            end
        end
        check("i_gnt", mif.i_gnt, gi);
        check("d_gnt", mif.d_gnt, gd);
        if (m_busy && ack) begin
            exp_q.push_back({m_own, rdata});
            m_busy = 1'b0;
        end else if (gi) begin
            m_busy = 1'b1;
            m_own  = OWN_I;
            e_addr = mif.i_addr;
            e_wen  = 1'b0;
            starve = 0;
            grant_log.push_back(OWN_I);
        end else if (gd) begin
            m_busy  = 1'b1;
            m_own   = OWN_D;
            e_addr  = mif.d_addr;
            e_wen   = mif.d_wen;
            e_wdata = mif.d_wdata;
            e_wmask = mif.d_wmask;
            starve  = want_i ? ((starve >= SMAX) ? SMAX : starve + 1) : 0;
            grant_log.push_back(OWN_D);
        end
        @(posedge clk);
        @(negedge clk);
        mif.m_ack = 1'b0;
        if (gi) mif.i_req = 1'b0;
        if (gd) mif.d_req = 1'b0;
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_fetch(input logic [AW-1:0] addr);
        mif.i_req  = 1'b1;
        mif.i_addr = addr;
    endtask

    task automatic drive_data(input logic wen, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] wmask);
        mif.d_req   = 1'b1;
        mif.d_wen   = wen;
        mif.d_addr  = addr;
        mif.d_wdata = wdata;
        mif.d_wmask = wmask;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        mif.m_ack   = 1'b0;
        mif.i_req   = 1'b1;
        mif.d_req   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_i_gnt", mif.i_gnt, 1'b0);
        mif.i_req = 1'b0;
        model_reset();
        check_outputs();
        check("rst_m_wen", mif.m_wen, 1'b0);
        check("rst_m_addr", mif.m_addr, '0);
        check("rst_m_wdata", mif.m_wdata, '0);
        check("rst_m_wmask", mif.m_wmask, '0);
        rst = 1'b0;
    endtask

    task automatic drive_random();
        if (!mif.i_req) begin
            if ($urandom_range(0, 2) == 0) drive_fetch($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
            mif.i_req = 1'b0;
        end
        if (!mif.d_req) begin
            if ($urandom_range(0, 2) == 0)
                drive_data(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
        end else if ($urandom_range(0, 19) == 0) begin
            mif.d_req = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    logic exp_order[6];

    initial begin
        mif.i_req = 1'b0; mif.i_addr = '0;
        mif.d_req = 1'b0; mif.d_wen = 1'b0; mif.d_addr = '0;
        mif.d_wdata = '0; mif.d_wmask = '0;
        mif.m_ack = 1'b0; mif.m_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Fetch only, zero-wait memory
        drive_fetch(32'h8000_0000);
        tick(1'b0, '0);
        check("fetch_m_addr", mif.m_addr, 32'h8000_0000);
        tick(1'b1, 32'h0000_0413);
        check("fetch_rvalid", mif.i_rvalid, 1'b1);
        check("fetch_rdata", mif.i_rdata, 32'h0000_0413);

        // Simultaneous requests: data first, fetch next
        drive_fetch(32'h8000_0004);
        drive_data(1'b0, 32'h8000_1000, '0, '0);
        tick(1'b0, '0);
        check("sim_m_addr_d", mif.m_addr, 32'h8000_1000);
        check("sim_starve1", dbg_starve_cnt, 1);
        tick(1'b1, 32'h1111_2222);
        check("sim_d_rdata", mif.d_rdata, 32'h1111_2222);
        tick(1'b0, '0);
        check("sim_m_addr_i", mif.m_addr, 32'h8000_0004);
        check("sim_starve0", dbg_starve_cnt, 0);
        tick(1'b1, 32'h3333_4444);

        // Write with three-cycle memory latency
        drive_data(1'b1, 32'h8000_2000, 32'hDEAD_BEEF, 32'h0000_FFFF);
        tick(1'b0, '0);
        tick(1'b0, '0);
        tick(1'b0, '0);
        check("wr_m_wdata", mif.m_wdata, 32'hDEAD_BEEF);
        tick(1'b1, 32'h5555_AAAA);
        check("wr_d_rvalid", mif.d_rvalid, 1'b1);
        check("wr_i_rvalid", mif.i_rvalid, 1'b0);

        // Stray ack while idle
        tick(1'b1, 32'hABCD_0123);
        check("stray_state", dbg_state, IDLE);
        check("stray_rvalid", {mif.i_rvalid, mif.d_rvalid}, 2'b00);

        // Starvation bound with both requesters always asking
        grant_log.delete();
        for (int c = 0; c < 14; c++) begin
            drive_fetch(32'h8000_0100 + 32'(c));
            drive_data(1'b0, 32'h8000_3000 + 32'(c), '0, '0);
            tick(m_busy, $urandom);
        end
        mif.i_req = 1'b0;
        mif.d_req = 1'b0;
        exp_order = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_I, OWN_D};
        check("starve_grants", grant_log.size() >= 6, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) check($sformatf("starve_order%0d", k), grant_log[k], exp_order[k]);
        end
        while (m_busy) tick(1'b1, $urandom);

        // Reset in the middle of a data transaction
        drive_data(1'b0, 32'h8000_4000, '0, '0);
        tick(1'b0, '0);
        tick(1'b0, '0);
        check("midrst_busy", dbg_state, BUSY_D);
        do_reset();
        check("midrst_m_req", mif.m_req, 1'b0);
        check("midrst_d_rvalid", mif.d_rvalid, 1'b0);
        tick(1'b0, '0);
        drive_fetch(32'h8000_0200);
        tick(1'b0, '0);
        check("midrst_fetch_state", dbg_state, BUSY_I);
        tick(1'b1, 32'h0000_0013);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            if (m_busy) tick(1'($urandom_range(0, 2) == 0), $urandom);
            else        tick(1'($urandom_range(0, 9) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified memory port between the CPU's instruction-fetch requester and its load/store requester, replacing the separate IRAM/DRAM paths when both live in one backing memory. Data accesses get priority. A starvation counter guarantees fetch progress. The block owns one outstanding memory transaction at a time and returns each response to the requester that issued it.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; the write mask is also DATA_W bits (bit-level mask)
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (≥1)

- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- i_req  input  1  fetch request; held with i_addr until i_gnt
- i_addr  input  ADDR_W  fetch address
- i_gnt  output  1  fetch request accepted (combinational, IDLE only)
- i_rvalid  output  1  one-cycle pulse: i_rdata valid
- i_rdata  output  DATA_W  fetched instruction
- d_req  input  1  data request; held with d_* until d_gnt
- d_wen  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_wmask  input  DATA_W  write bit mask
- d_gnt  output  1  data request accepted (combinational, IDLE only)
- d_rvalid  output  1  one-cycle pulse: read data valid, or write complete
- d_rdata  output  DATA_W  read data
- m_req  output  1  memory request, held until m_ack
- m_wen, m_addr, m_wdata, m_wmask  output  1/ADDR_W/DATA_W/DATA_W  latched request fields
- m_ack  input  1  memory completes the current request; m_rdata valid this cycle
- m_rdata  input  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: arbitrate among the current requests.
  - Only one request present: that request wins.
  - Both present: D wins, unless starve_cnt == STARVE_MAX; then I wins.
  - Winner gets its gnt in the same cycle.
  - Winner's fields are latched into the m_* registers.
  - State moves to BUSY_I or BUSY_D.
- starve_cnt (width clog2(STARVE_MAX+1)) updates only on a grant:
  - D granted while i_req=1: +1, saturating at STARVE_MAX.
  - I granted: cleared to 0.
  - D granted while i_req=0: cleared to 0.
- BUSY_x: m_req=1 with stable fields.
  - On m_ack: capture m_rdata into x_rdata, pulse x_rvalid next cycle, return to IDLE.
  - i_gnt and d_gnt are 0 in BUSY states.
- Writes: d_rvalid pulses as the completion signal; d_rdata takes whatever m_rdata carried at ack.
- A request withdrawn before its gnt is ignored with no side effect.
- Requesters give no backpressure: the rvalid pulse must be consumed in its cycle.
- i_rdata and d_rdata hold their last value between pulses.

## Timing
- Cycle 0: req seen in IDLE, gnt=1.
- Cycle 1: m_req=1, m_* valid.
- Memory acks at cycle k≥1; x_rvalid=1 at k+1.
- Next grant is possible at cycle k+1 in IDLE, so zero-wait memory gives one transaction per 2 cycles.
- m_ack while IDLE is ignored.
- m_ack and a new req in the same cycle: the req waits; arbitration happens in the following IDLE cycle.
- Reset (any cycle, including mid-transaction):
  - Next cycle: state IDLE, starve_cnt 0.
  - m_req, m_wen, i_gnt, d_gnt, i_rvalid, d_rvalid all 0.
  - m_addr, m_wdata, m_wmask, i_rdata, d_rdata all 0.
  - The in-flight transaction is abandoned with no rvalid.
  - The memory must drop an un-acked request when m_req falls.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY_I, BUSY_D}.
  - owner enum {OWN_I, OWN_D}.
  - Default STARVE_MAX constant.
- One natural sub-module: mem_arb_pick, the combinational winner select from (i_req, d_req, starve_cnt==STARVE_MAX). Everything else stays in mem_arbiter.

## Test plan
- Fetch only:
  - Stimulus: i_req, i_addr=0x80000000; memory acks at cycle 1 with 0x00000413.
  - Required: i_gnt at cycle 0, m_req/m_addr=0x80000000 at cycle 1, i_rvalid and i_rdata=0x00000413 at cycle 2.
- Simultaneous single requests:
  - Stimulus: i_req and d_req (read 0x80001000) together.
  - Required: d_gnt first, d_rvalid returns, then i_gnt in the next IDLE; starve_cnt=1 then 0.
- Starvation bound:
  - Stimulus: i_req and d_req held high continuously, STARVE_MAX=4.
  - Required: grant order D,D,D,D,I,D,…
- Write:
  - Stimulus: d_wen=1, d_addr=0x80002000, d_wdata=0xDEADBEEF, d_wmask=0x0000FFFF; memory acks after 3 cycles.
  - Required: m_* stable for all 3 cycles, d_rvalid 1 cycle after ack, no i_rvalid.
- Reset mid-transaction:
  - Stimulus: rst asserted in BUSY_D before m_ack.
  - Required: next cycle m_req=0, no d_rvalid, state IDLE; a subsequent i_req is granted normally.
- Stray ack:
  - Stimulus: m_ack pulsed while IDLE.
  - Required: no rvalid, no state change.
